fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath/PC width; SHALL be >= 32.
REQ-002 Parameter RESET_VECTOR, default 32'h0, PC value loaded on reset.
REQ-003 Parameter PC_INC, default 4, auto-increment step after each fetch.
REQ-004 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_halt  in  1  blocks issue of new fetches.
REQ-007 i_pc_we  in  1  redirect strobe from control.
REQ-008 i_pc_src  in  2  redirect source: 00 i_alu_result, 01 i_alu_out, 10 jump target, 11 no change.
REQ-009 i_alu_result, i_alu_out  in  XLEN  redirect operands.
REQ-010 i_instr_ack  in  1  consumer has taken o_instr.
REQ-011 o_imem_req  out  1;  o_imem_addr  out  XLEN;  i_imem_ack  in  1;  i_imem_rdata  in  32  instruction-memory handshake.
REQ-012 o_pc  out  XLEN;  o_instr  out  32;  o_instr_valid  out  1;  o_misalign  out  1.

Function
REQ-013 FSM states IDLE, REQ, HAVE SHALL be the only states.
REQ-014 IDLE -> REQ on the first edge with i_halt=0; otherwise remain IDLE.
REQ-015 In REQ, o_imem_req SHALL be 1 and o_imem_addr SHALL equal o_pc, stable until i_imem_ack.
REQ-016 i_imem_ack SHALL be accepted in any REQ cycle, including the first; on it: o_instr <= i_imem_rdata, o_pc <= o_pc + PC_INC (mod 2^XLEN), state -> HAVE.
REQ-017 o_instr_valid SHALL be 1 exactly while in HAVE; o_imem_req 0 outside REQ.
REQ-018 In HAVE with i_instr_ack=1: state -> REQ if i_halt=0, else -> IDLE.
REQ-019 i_pc_we SHALL be honoured only in HAVE; in IDLE and REQ it SHALL be ignored.
REQ-020 Redirect in HAVE loads o_pc with the selected source on that edge; when simultaneous with i_instr_ack, the following REQ SHALL use the redirected PC.
REQ-021 Jump target = {o_pc[XLEN-1:28], o_instr[31:6], 2'b00}, using the already-incremented PC.
REQ-022 i_pc_src=11 with i_pc_we=1 SHALL leave o_pc unchanged.
REQ-023 i_halt asserted in REQ SHALL NOT abort the outstanding fetch; it takes effect at the next HAVE -> transition.
REQ-024 Fetch latency: one cycle IDLE->REQ, then i_imem_ack cycle, then o_instr_valid on the next cycle.

Reset
REQ-025 On i_reset: o_pc=RESET_VECTOR, o_instr=0, o_instr_valid=0, o_imem_req=0, o_misalign=0, state IDLE.
REQ-026 Reset mid-REQ SHALL abandon the outstanding request; a late i_imem_ack after reset release in IDLE SHALL be ignored.

Configuration
REQ-027 With ARGON_MISALIGN_TRAP_EN defined: a redirect whose target has bits [1:0] != 0 SHALL NOT load o_pc, SHALL set o_misalign (sticky until reset), and force state to IDLE permanently until reset.
REQ-028 Without ARGON_MISALIGN_TRAP_EN: redirect targets SHALL be loaded with bits [1:0] forced to 0; o_misalign tied 0.

Structure
REQ-029 Shared package argon_pkg SHALL hold pc_src_e (PCSRC_ALU_RESULT, PCSRC_ALU_OUT, PCSRC_JUMP, PCSRC_HOLD), fetch_state_e, and PC_INC default.
REQ-030 Target selection and jump-target formation SHALL live in one combinational sub-module pc_target_sel; FSM, PC and instruction register in fetch_unit.

Verification
REQ-031 Reset, i_halt=0, imem acks 0 cycles late with 32'hDEADBEEF -> req at addr 0, o_instr=32'hDEADBEEF valid, o_pc=4.
REQ-032 Three back-to-back fetches with 2-cycle ack delay -> addresses 0,4,8; o_imem_addr stable throughout each wait.
REQ-033 In HAVE, i_pc_we=1, i_pc_src=10, o_pc=32'h1000_0004, o_instr[31:6]=26'h0000040 -> next fetch at 32'h1000_0100.
REQ-034 i_halt=1 during REQ -> fetch completes, after i_instr_ack state IDLE, o_imem_req=0 until i_halt=0.
REQ-035 Redirect to 32'h0000_0102: with ARGON_MISALIGN_TRAP_EN o_misalign=1 and no further requests; without it next fetch at 32'h0000_0100.
REQ-036 Assert i_reset during REQ wait, then late i_imem_ack -> o_pc=RESET_VECTOR, o_instr_valid=0, ack ignored.

Source files
------------

// File: rtl/argon_pkg.sv
// -----------------------------------------------------------------------------
// argon_pkg
//   Shared types and constants for the Argon fetch path.
//
//   pc_src_e       : redirect source select driven by the control unit
//   fetch_state_e  : fetch FSM state encoding (IDLE, REQ, HAVE only)
//   PC_INC_DEFAULT : default auto-increment step applied after each fetch
//   INSTR_W        : instruction word width (fixed at 32 regardless of XLEN)
// -----------------------------------------------------------------------------
package argon_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU_RESULT = 2'b00,
    PCSRC_ALU_OUT    = 2'b01,
    PCSRC_JUMP       = 2'b10,
    PCSRC_HOLD       = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HAVE = 2'b10
  } fetch_state_e;

  localparam int unsigned PC_INC_DEFAULT = 4;
  localparam int unsigned INSTR_W        = 32;

endpackage : argon_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory request/acknowledge bundle between the fetch unit and
//   the instruction memory.
//
//   o_imem_req   : fetch unit -> memory, request pending
//   o_imem_addr  : fetch unit -> memory, fetch address (XLEN)
//   i_imem_ack   : memory -> fetch unit, read data valid this cycle
//   i_imem_rdata : memory -> fetch unit, instruction word (32)
//
//   Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_ack;
  logic [31:0]     i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_pc_target_sel.sv
// -----------------------------------------------------------------------------
// pc_target_sel
//   Purely combinational redirect-target selection for the fetch unit.
//
//   pc_src     : redirect source (pc_src_e)
//   alu_result : candidate target, source 00
//   alu_out    : candidate target, source 01
//   pc         : current (already incremented) PC; supplies the jump region
//                bits and the HOLD value
//   jump_imm   : instruction bits [31:6], the word-index part of a jump
//   target     : selected redirect target
//   misaligned : target has nonzero bits [1:0] and is a real redirect
//                (HOLD never counts as misaligned, it does not move the PC)
// -----------------------------------------------------------------------------
module pc_target_sel
  import argon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  pc_src_e         pc_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     jump_imm,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    target = pc;
    unique case (pc_src)
      PCSRC_ALU_RESULT: target = alu_result;
      PCSRC_ALU_OUT:    target = alu_out;
      // Region bits come from the post-increment PC, so a jump sitting in the
      // last word of a 256 MiB region lands in the next region.
      PCSRC_JUMP:       target = {pc[XLEN-1:28], jump_imm, 2'b00};
      PCSRC_HOLD:       target = pc;
    endcase
    misaligned = (pc_src != PCSRC_HOLD) && (target[1:0] != 2'b00);
  end

endmodule : pc_target_sel

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding instruction fetcher. A three-state FSM (IDLE, REQ,
//   HAVE) issues one request on the instruction-memory bus, captures the
//   returned word, presents it to the consumer and then either fetches again
//   or parks in IDLE while i_halt is high. Control may redirect the PC only
//   while an instruction is being presented (HAVE).
//
//   Parameters
//     XLEN         : PC / datapath width, must be >= 32
//     RESET_VECTOR : PC value after reset
//     PC_INC       : step added to the PC when a fetch completes
//
//   Ports
//     i_clk, i_reset : clock, asynchronous active-high reset
//     i_halt         : hold off new fetches (an outstanding one completes)
//     i_pc_we        : redirect strobe, honoured in HAVE only
//     i_pc_src       : redirect source (see argon_pkg::pc_src_e)
//     i_alu_result   : redirect operand for source 00
//     i_alu_out      : redirect operand for source 01
//     i_instr_ack    : consumer has taken o_instr
//     imem           : instruction-memory bus (fetch_unit_if.master)
//     o_pc           : next fetch address / post-increment PC
//     o_instr        : last fetched instruction
//     o_instr_valid  : high exactly while in HAVE
//     o_misalign     : sticky misaligned-redirect trap flag
//
//   Build option ARGON_MISALIGN_TRAP_EN:
//     defined   - a misaligned redirect is refused, o_misalign latches high
//                 and the unit parks in IDLE until reset.
//     undefined - redirect targets are word-aligned by clearing bits [1:0];
//                 o_misalign is constant 0.
// -----------------------------------------------------------------------------
module fetch_unit
  import argon_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_INC       = PC_INC_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_halt,
  input  logic             i_pc_we,
  input  logic [1:0]       i_pc_src,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_alu_out,
  input  logic             i_instr_ack,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  o_pc,
  output logic [31:0]      o_instr,
  output logic             o_instr_valid,
  output logic             o_misalign
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  logic            req_q;
  logic            trapped_q;

  pc_src_e         pc_src;
  logic [XLEN-1:0] sel_target;
  logic            sel_misaligned;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_traps;
  logic            redirect_moves;

  assign pc_src = pc_src_e'(i_pc_src);

  pc_target_sel #(
    .XLEN (XLEN)
  ) u_pc_target_sel (
    .pc_src     (pc_src),
    .alu_result (i_alu_result),
    .alu_out    (i_alu_out),
    .pc         (pc_q),
    .jump_imm   (instr_q[31:6]),
    .target     (sel_target),
    .misaligned (sel_misaligned)
  );

  // HOLD is filtered here rather than relying on target == pc, so a HOLD
  // never disturbs a PC that is itself unaligned (e.g. an odd RESET_VECTOR).
  assign redirect_moves = i_pc_we && (pc_src != PCSRC_HOLD);

`ifdef ARGON_MISALIGN_TRAP_EN
  assign redirect_pc    = sel_target;
  assign redirect_traps = sel_misaligned;
  assign o_misalign     = trapped_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = sel_misaligned;
  assign redirect_pc    = {sel_target[XLEN-1:2], 2'b00};
  assign redirect_traps = 1'b0;
  assign o_misalign     = 1'b0;
`endif

  // Registered FSM: all handshake outputs are flops updated alongside state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (i_reset) begin
      // NOTE: every register here is control/datapath state with a defined
      // reset value; there is no storage array, so nothing is left unreset.
      state     <= ST_IDLE;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      trapped_q <= 1'b0;
    end else begin
      unique case (state)
        // Ack strobes arriving here (e.g. a late ack for a request abandoned
        // by reset) are deliberately ignored.
        ST_IDLE: begin
          if (!i_halt && !trapped_q) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end

        // Address is o_pc and cannot change here, since redirects are
        // ignored outside HAVE. i_halt does not abort the fetch.
        ST_REQ: begin
          if (imem.i_imem_ack) begin
            instr_q <= imem.i_imem_rdata;
            pc_q    <= pc_q + PC_STEP;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= ST_HAVE;
          end
        end

        ST_HAVE: begin
          if (redirect_moves && redirect_traps) begin
            // Refused redirect: PC keeps its value, the unit parks for good.
            trapped_q <= 1'b1;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            if (redirect_moves) begin
              pc_q <= redirect_pc;
            end
            // A redirect on the same edge as the consumer ack is already in
            // pc_q when REQ drives the address.
            if (i_instr_ack) begin
              valid_q <= 1'b0;
              if (!i_halt) begin
                req_q <= 1'b1;
                state <= ST_REQ;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          valid_q <= 1'b0;
          req_q   <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc_q;
  assign o_pc             = pc_q;
  assign o_instr          = instr_q;
  assign o_instr_valid    = valid_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A table of fetch records drives the
//   memory side (ack delay, returned word) and the consumer side (redirect on
//   the ack edge); expected {pc, instr} pairs go into a scoreboard queue when
//   a request is answered and are popped when o_instr_valid appears.
//   Hand-written sequences cover halt during REQ, misaligned redirect and
//   reset in the middle of an outstanding request.
//   Define ARGON_MISALIGN_TRAP_EN for both bench and RTL to check the trap
//   build.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import argon_pkg::*;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] STEP  = 32'd4;
  localparam int          WAIT_LIMIT = 20;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_halt;
  logic        i_pc_we;
  logic [1:0]  i_pc_src;
  logic [31:0] i_alu_result;
  logic [31:0] i_alu_out;
  logic        i_instr_ack;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        o_misalign;

  fetch_unit_if #(.XLEN(XLEN)) imem ();

  fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .PC_INC       (4)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_halt        (i_halt),
    .i_pc_we       (i_pc_we),
    .i_pc_src      (i_pc_src),
    .i_alu_result  (i_alu_result),
    .i_alu_out     (i_alu_out),
    .i_instr_ack   (i_instr_ack),
    .imem          (imem),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_misalign    (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    int unsigned delay;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
  } vec_t;

  vec_t vecs[9];
  vec_t b2b[3];

  // Wait (bounded) for a request, serve it after v.delay cycles, check the
  // presented instruction, then ack it with the record's redirect applied.
  task automatic run_vec(input vec_t v, input string tag);
    int   waited;
    sb_t  exp;
    waited = 0;
    while (imem.o_imem_req !== 1'b1 && waited < WAIT_LIMIT) begin
      @(negedge i_clk);
      waited++;
    end
    check($sformatf("%s req", tag), {31'b0, imem.o_imem_req}, 32'd1);
    check($sformatf("%s addr", tag), imem.o_imem_addr, v.exp_addr);
    check($sformatf("%s valid_in_req", tag), {31'b0, o_instr_valid}, 32'd0);
    sb_q.push_back('{pc: v.exp_addr + STEP, instr: v.rdata});

    for (int d = 0; d < int'(v.delay); d++) begin
      // Redirect attempts while waiting must not move the address.
      i_pc_we      = 1'b1;
      i_pc_src     = 2'b00;
      i_alu_result = 32'hAAAA_0000;
      @(negedge i_clk);
      check($sformatf("%s wait%0d req", tag, d), {31'b0, imem.o_imem_req}, 32'd1);
      check($sformatf("%s wait%0d addr", tag, d), imem.o_imem_addr, v.exp_addr);
    end
    i_pc_we = 1'b0;

    imem.i_imem_ack   = 1'b1;
    imem.i_imem_rdata = v.rdata;
    @(negedge i_clk);
    imem.i_imem_ack   = 1'b0;
    imem.i_imem_rdata = 32'hBAD0_BAD0;

    check($sformatf("%s valid", tag), {31'b0, o_instr_valid}, 32'd1);
    check($sformatf("%s req_in_have", tag), {31'b0, imem.o_imem_req}, 32'd0);
    if (sb_q.size() == 0) begin
      check($sformatf("%s scoreboard_empty", tag), 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check($sformatf("%s instr", tag), o_instr, exp.instr);
      check($sformatf("%s pc", tag), o_pc, exp.pc);
    end

    i_instr_ack  = 1'b1;
    i_pc_we      = v.pc_we;
    i_pc_src     = v.pc_src;
    i_alu_result = v.alu_result;
    i_alu_out    = v.alu_out;
    @(negedge i_clk);
    i_instr_ack  = 1'b0;
    i_pc_we      = 1'b0;
    i_pc_src     = 2'b11;
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    i_halt  = 1'b1;
    @(negedge i_clk);
    check($sformatf("%s pc", tag), o_pc, RV);
    check($sformatf("%s instr", tag), o_instr, 32'd0);
    check($sformatf("%s valid", tag), {31'b0, o_instr_valid}, 32'd0);
    check($sformatf("%s req", tag), {31'b0, imem.o_imem_req}, 32'd0);
    check($sformatf("%s misalign", tag), {31'b0, o_misalign}, 32'd0);
    sb_q.delete();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {delay, rdata, exp_addr, pc_we, pc_src, alu_result, alu_out}
    vecs[0] = '{0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2'b11, 32'h0,         32'h0};
    vecs[1] = '{2, 32'h1111_1111, 32'h0000_0004, 1'b0, 2'b11, 32'h0,         32'h0};
    vecs[2] = '{2, 32'h2222_2222, 32'h0000_0008, 1'b1, 2'b00, 32'h1000_0000, 32'h0};
    vecs[3] = '{1, 32'h0000_103F, 32'h1000_0000, 1'b1, 2'b10, 32'h0,         32'h0};
    vecs[4] = '{0, 32'h3333_3333, 32'h1000_0100, 1'b1, 2'b01, 32'h0,         32'h0000_0200};
    vecs[5] = '{1, 32'h4444_4444, 32'h0000_0200, 1'b1, 2'b11, 32'hABCD_0000, 32'hABCD_0000};
    vecs[6] = '{3, 32'h5555_5555, 32'h0000_0204, 1'b1, 2'b01, 32'h0,         32'hFFFF_FFFC};
    vecs[7] = '{0, 32'h6666_6666, 32'hFFFF_FFFC, 1'b0, 2'b11, 32'h0,         32'h0};
    vecs[8] = '{2, 32'h7777_7777, 32'h0000_0000, 1'b0, 2'b11, 32'h0,         32'h0};

    b2b[0]  = '{2, 32'hA000_0001, 32'h0000_0000, 1'b0, 2'b11, 32'h0, 32'h0};
    b2b[1]  = '{2, 32'hA000_0002, 32'h0000_0004, 1'b0, 2'b11, 32'h0, 32'h0};
    b2b[2]  = '{2, 32'hA000_0003, 32'h0000_0008, 1'b0, 2'b11, 32'h0, 32'h0};

    i_reset           = 1'b1;
    i_halt            = 1'b1;
    i_pc_we           = 1'b0;
    i_pc_src          = 2'b11;
    i_alu_result      = '0;
    i_alu_out         = '0;
    i_instr_ack       = 1'b0;
    imem.i_imem_ack   = 1'b0;
    imem.i_imem_rdata = '0;

    do_reset("reset0");
    i_halt = 1'b0;
    @(negedge i_clk);
    // One edge after release with i_halt low: request is already up.
    check("latency req", {31'b0, imem.o_imem_req}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Halt raised during REQ: fetch completes, then the unit parks.
    check("halt req", {31'b0, imem.o_imem_req}, 32'd1);
    check("halt addr", imem.o_imem_addr, 32'h0000_0004);
    i_halt = 1'b1;
    @(negedge i_clk);
    check("halt req_kept", {31'b0, imem.o_imem_req}, 32'd1);
    imem.i_imem_ack   = 1'b1;
    imem.i_imem_rdata = 32'h8888_8888;
    @(negedge i_clk);
    imem.i_imem_ack   = 1'b0;
    check("halt valid", {31'b0, o_instr_valid}, 32'd1);
    check("halt instr", o_instr, 32'h8888_8888);
    i_instr_ack = 1'b1;
    @(negedge i_clk);
    i_instr_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("halt idle%0d req", k), {31'b0, imem.o_imem_req}, 32'd0);
      check($sformatf("halt idle%0d valid", k), {31'b0, o_instr_valid}, 32'd0);
      check($sformatf("halt idle%0d pc", k), o_pc, 32'h0000_0008);
      i_pc_we   = 1'b1;
      i_pc_src  = 2'b01;
      i_alu_out = 32'h0000_4000;
      @(negedge i_clk);
    end
    i_pc_we = 1'b0;
    check("halt idle_pc_we_ignored", o_pc, 32'h0000_0008);
    i_halt = 1'b0;
    @(negedge i_clk);
    check("halt resume req", {31'b0, imem.o_imem_req}, 32'd1);
    check("halt resume addr", imem.o_imem_addr, 32'h0000_0008);

    // Misaligned redirect to 0x102.
    imem.i_imem_ack   = 1'b1;
    imem.i_imem_rdata = 32'h9999_9999;
    @(negedge i_clk);
    imem.i_imem_ack   = 1'b0;
    check("mis valid", {31'b0, o_instr_valid}, 32'd1);
    check("mis pc", o_pc, 32'h0000_000C);
    i_instr_ack  = 1'b1;
    i_pc_we      = 1'b1;
    i_pc_src     = 2'b00;
    i_alu_result = 32'h0000_0102;
    @(negedge i_clk);
    i_instr_ack  = 1'b0;
    i_pc_we      = 1'b0;
`ifdef ARGON_MISALIGN_TRAP_EN
    check("mis flag", {31'b0, o_misalign}, 32'd1);
    check("mis pc_kept", o_pc, 32'h0000_000C);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mis park%0d req", k), {31'b0, imem.o_imem_req}, 32'd0);
      check($sformatf("mis park%0d valid", k), {31'b0, o_instr_valid}, 32'd0);
      @(negedge i_clk);
    end
    check("mis sticky", {31'b0, o_misalign}, 32'd1);
`else
    check("mis flag", {31'b0, o_misalign}, 32'd0);
    check("mis req", {31'b0, imem.o_imem_req}, 32'd1);
    check("mis addr", imem.o_imem_addr, 32'h0000_0100);
`endif

    // Reset while a request is outstanding, then a late ack in IDLE.
    do_reset("reset1");
    i_halt = 1'b0;
    @(negedge i_clk);
    check("rstmid req", {31'b0, imem.o_imem_req}, 32'd1);
    repeat (2) @(negedge i_clk);
    do_reset("rstmid");
    imem.i_imem_ack   = 1'b1;
    imem.i_imem_rdata = 32'h0BAD_0BAD;
    @(negedge i_clk);
    imem.i_imem_ack   = 1'b0;
    check("late_ack pc", o_pc, RV);
    check("late_ack valid", {31'b0, o_instr_valid}, 32'd0);
    check("late_ack instr", o_instr, 32'd0);
    check("late_ack req", {31'b0, imem.o_imem_req}, 32'd0);

    // Three back-to-back fetches with a 2-cycle ack delay.
    i_halt = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      run_vec(b2b[i], $sformatf("b2b%0d", i));
    end
    check("b2b final addr", imem.o_imem_addr, 32'h0000_000C);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
